// File: rtl/risc_ctrl_seq_if.sv
// Control/status bundle between the RISC sequencer and the datapath/program memory.
// The sequencer sits on the slave side; the datapath/bench drives Run/Instr.
interface risc_ctrl_seq_if #(
  parameter int IW    = 8,
  parameter int NREG  = 4,
  parameter int CNT_W = 8
);
  logic             Run;
  logic [IW-1:0]    Instr;
  logic             MemRd;
  logic             PcInc;
  logic             Cen;
  logic [NREG-1:0]  RegEn;
  logic [1:0]       SrcSel;
  logic [2:0]       AluOp;
  logic [1:0]       RsSel;
  logic             Halted;
  logic [CNT_W-1:0] RetCnt;

  modport slave (
    input  Run, Instr,
    output MemRd, PcInc, Cen, RegEn, SrcSel, AluOp, RsSel, Halted, RetCnt
  );

  modport master (
    output Run, Instr,
    input  MemRd, PcInc, Cen, RegEn, SrcSel, AluOp, RsSel, Halted, RetCnt
  );
endinterface

// File: rtl/risc_ctrl_seq.sv
// Multi-cycle instruction sequencer for the 8-bit RISC CPU: drives register-bank
// write enables, source select, ALU opcode, PC/memory strobes and a retire counter.
module risc_ctrl_seq #(
  parameter int IW    = 8,
  parameter int NREG  = 4,
  parameter int CNT_W = 8
) (
  input  logic           i_Clk,
  input  logic           i_Rst,   // active low, asynchronous
  risc_ctrl_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_IMM, S_WB, S_HALT
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;
  localparam logic [1:0] SRC_REG = 2'b10;

  state_t           r_state, w_next;
  logic [IW-1:0]    r_ir;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;

  logic [2:0]       w_op;
  logic [1:0]       w_rd, w_rs;
  logic [NREG-1:0]  w_onehot;

  logic             w_memrd, w_pcinc, w_cen;
  logic [NREG-1:0]  w_regen;
  logic [1:0]       w_srcsel, w_rssel;
  logic [2:0]       w_aluop;

  assign w_op     = r_ir[7:5];
  assign w_rd     = r_ir[4:3];
  assign w_rs     = r_ir[2:1];
  assign w_onehot = {{(NREG-1){1'b0}}, 1'b1} << w_rd;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) r_ir  <= bus.Instr;
      if (w_retire)           r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.Run) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_NOP: begin w_next = S_FETCH; w_retire = 1'b1; end
          OP_HLT: begin w_next = S_HALT;  w_retire = 1'b1; end
          OP_LDI: w_next = S_IMM;
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC:   w_next = S_WB;
      S_IMM:    w_next = S_WB;
      S_WB: begin
        w_retire = 1'b1;
        w_next   = bus.Run ? S_FETCH : S_IDLE;
      end
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // Moore outputs: only r_state and r_ir feed these, so they settle well before the negedge capture.
  always_comb begin
    w_memrd  = 1'b0;
    w_pcinc  = 1'b0;
    w_cen    = 1'b0;
    w_regen  = '0;
    w_srcsel = SRC_ALU;
    w_aluop  = 3'b000;
    w_rssel  = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_memrd = 1'b1;
        w_pcinc = 1'b1;
      end
      S_EXEC: begin
        w_aluop  = w_op;
        w_rssel  = w_rs;
        w_srcsel = (w_op == OP_MOV) ? SRC_REG : SRC_ALU;
      end
      S_IMM: begin
        w_memrd  = 1'b1;
        w_pcinc  = 1'b1;
        w_srcsel = SRC_IMM;
      end
      S_WB: begin
        // WB repeats whatever EXEC/IMM presented so the register sees a stable source.
        w_cen   = 1'b1;
        w_regen = w_onehot;
        w_rssel = w_rs;
        if (w_op == OP_LDI) begin
          w_srcsel = SRC_IMM;
        end else begin
          w_aluop  = w_op;
          w_srcsel = (w_op == OP_MOV) ? SRC_REG : SRC_ALU;
        end
      end
      default: ;
    endcase
  end

  assign bus.MemRd  = w_memrd;
  assign bus.PcInc  = w_pcinc;
  assign bus.Cen    = w_cen;
  assign bus.RegEn  = w_regen;
  assign bus.SrcSel = w_srcsel;
  assign bus.AluOp  = w_aluop;
  assign bus.RsSel  = w_rssel;
  assign bus.Halted = (r_state == S_HALT);
  assign bus.RetCnt = r_cnt;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Scoreboard bench for risc_ctrl_seq: each step pushes the expected output record,
// the observed record is captured after the edge, and each test drains and compares.
module tb_risc_ctrl_seq;

  typedef struct packed {
    logic       memrd;
    logic       pcinc;
    logic       cen;
    logic [3:0] regen;
    logic [1:0] srcsel;
    logic [2:0] aluop;
    logic [1:0] rssel;
    logic       halted;
    logic [7:0] retcnt;
  } rec_t;

  localparam logic [7:0] I_NOP = 8'b000_00_00_0;
  localparam logic [7:0] I_HLT = 8'b111_00_00_0;
  localparam logic [7:0] I_ADD = 8'b001_10_01_0;
  localparam logic [7:0] I_SUB = 8'b010_00_11_1;
  localparam logic [7:0] I_OR  = 8'b100_11_10_0;
  localparam logic [7:0] I_LDI = 8'b101_11_00_0;
  localparam logic [7:0] I_MOV = 8'b110_01_10_0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  risc_ctrl_seq_if bus ();

  risc_ctrl_seq dut (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];
  logic [7:0] dreg3 = 8'h00;

  function automatic rec_t obs_now();
    return {bus.MemRd, bus.PcInc, bus.Cen, bus.RegEn, bus.SrcSel,
            bus.AluOp, bus.RsSel, bus.Halted, bus.RetCnt};
  endfunction

  function automatic rec_t mk(logic mr, logic pi, logic cen, logic [3:0] re,
                              logic [1:0] ss, logic [2:0] op, logic [1:0] rs,
                              logic h, logic [7:0] rc);
    return {mr, pi, cen, re, ss, op, rs, h, rc};
  endfunction

  function automatic rec_t e_idle(logic [7:0] r);  return mk(0,0,0,4'b0,2'b00,3'b000,2'b00,0,r); endfunction
  function automatic rec_t e_fetch(logic [7:0] r); return mk(1,1,0,4'b0,2'b00,3'b000,2'b00,0,r); endfunction
  function automatic rec_t e_imm(logic [7:0] r);   return mk(1,1,0,4'b0,2'b01,3'b000,2'b00,0,r); endfunction
  function automatic rec_t e_halt(logic [7:0] r);  return mk(0,0,0,4'b0,2'b00,3'b000,2'b00,1,r); endfunction
  function automatic rec_t e_exec(logic [2:0] op, logic [1:0] rs, logic [1:0] ss, logic [7:0] r);
    return mk(0,0,0,4'b0,ss,op,rs,0,r);
  endfunction
  function automatic rec_t e_wb(logic [3:0] re, logic [1:0] ss, logic [2:0] op, logic [1:0] rs, logic [7:0] r);
    return mk(0,0,1,re,ss,op,rs,0,r);
  endfunction

  // Drive inputs for the coming posedge, push its expected result, capture what the DUT shows.
  task automatic step(input logic run, input logic [7:0] ins, input rec_t e);
    bus.Run   = run;
    bus.Instr = ins;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    obs_q.push_back(obs_now());
  endtask

  task automatic do_reset();
    bus.Run   = 1'b0;
    bus.Instr = 8'h00;
    rst_n     = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Register-bank r3 model: captures Inrs on the negedge when enabled with the immediate source.
  always @(negedge clk)
    if (bus.Cen && bus.RegEn[3] && bus.SrcSel == 2'b01) dreg3 <= bus.Instr;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (bus.Cen ? ($countones(bus.RegEn) != 1) : (bus.RegEn != 4'b0)) begin
        errors++;
        $display("FAIL cen_regen_invariant t=%0t cen=%b regen=%b", $time, bus.Cen, bus.RegEn);
      end
    end
  end

  task automatic test_reset();
    rec_t e, o;
    do_reset();
    checks++;
    if (obs_now() !== e_idle(8'd0)) begin
      errors++;
      $display("FAIL reset_release got %h exp %h", obs_now(), e_idle(8'd0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'($urandom), e_idle(8'd0));
    // Run one NOP then get into EXEC of an ADD, then pull reset asynchronously.
    step(1, 8'h00, e_fetch(0));
    step(1, I_NOP, e_idle(0));
    step(1, 8'h00, e_fetch(1));
    step(1, I_ADD, e_idle(1));
    step(1, 8'h00, e_exec(3'b001, 2'b01, 2'b00, 1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_seq got %h exp %h", o, e); end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_now() !== e_idle(8'd0)) begin
      errors++;
      $display("FAIL reset_mid_exec got %h exp %h", obs_now(), e_idle(8'd0));
    end
    @(posedge clk); #2; rst_n = 1'b1;
    // Reach WB and reset there: Cen/RegEn must drop before the negedge.
    step(1, 8'h00, e_fetch(0));
    step(1, I_ADD, e_idle(0));
    step(1, 8'h00, e_exec(3'b001, 2'b01, 2'b00, 0));
    step(1, 8'h00, e_wb(4'b0100, 2'b00, 3'b001, 2'b01, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_wb_seq got %h exp %h", o, e); end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.Cen !== 1'b0 || bus.RegEn !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid_wb cen=%b regen=%b exp 0/0000", bus.Cen, bus.RegEn);
    end
    @(posedge clk); #2; rst_n = 1'b1;
  endtask

  task automatic test_add();
    rec_t e, o;
    do_reset();
    step(1, 8'h00, e_fetch(0));
    step(1, I_ADD, e_idle(0));
    step(1, 8'h00, e_exec(3'b001, 2'b01, 2'b00, 0));
    step(0, 8'h00, e_wb(4'b0100, 2'b00, 3'b001, 2'b01, 0));
    step(0, 8'h00, e_idle(1));
    step(0, 8'h00, e_idle(1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL add got %h exp %h", o, e); end
    end
  endtask

  task automatic test_ldi();
    rec_t e, o;
    int pcs = 0;
    do_reset();
    step(1, 8'h00, e_fetch(0));
    step(1, I_LDI, e_idle(0));
    step(1, 8'h00, e_imm(0));
    step(0, 8'hA5, e_wb(4'b1000, 2'b01, 3'b000, 2'b00, 0));
    step(0, 8'hA5, e_idle(1));
    step(0, 8'h00, e_idle(1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.pcinc) pcs++;
      if (o !== e) begin errors++; $display("FAIL ldi got %h exp %h", o, e); end
    end
    checks++;
    if (pcs != 2) begin errors++; $display("FAIL ldi_pcinc_count got %0d exp 2", pcs); end
    checks++;
    if (dreg3 !== 8'hA5) begin errors++; $display("FAIL ldi_reg_capture got %h exp a5", dreg3); end
  endtask

  task automatic test_nop_hlt();
    rec_t e, o;
    do_reset();
    step(1, 8'h00, e_fetch(0));
    step(1, I_NOP, e_idle(0));
    step(1, 8'h00, e_fetch(1));
    step(1, I_HLT, e_idle(1));
    for (int i = 0; i < 6; i++) step(logic'(i % 2), 8'h00, e_halt(2));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL nop_hlt got %h exp %h", o, e); end
    end
  endtask

  task automatic test_run_drop();
    rec_t e, o;
    do_reset();
    step(1, 8'h00, e_fetch(0));
    step(1, I_MOV, e_idle(0));
    step(1, 8'h00, e_exec(3'b110, 2'b10, 2'b10, 0));
    step(0, 8'h00, e_wb(4'b0010, 2'b10, 3'b110, 2'b10, 0));
    for (int i = 0; i < 3; i++) step(0, 8'h00, e_idle(1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL run_drop got %h exp %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    do_reset();
    step(1, 8'h00, e_fetch(0));
    step(1, I_ADD, e_idle(0));
    step(1, 8'h00, e_exec(3'b001, 2'b01, 2'b00, 0));
    step(1, 8'h00, e_wb(4'b0100, 2'b00, 3'b001, 2'b01, 0));
    step(1, 8'h00, e_fetch(1));
    step(1, I_SUB, e_idle(1));
    step(1, 8'h00, e_exec(3'b010, 2'b11, 2'b00, 1));
    step(1, 8'h00, e_wb(4'b0001, 2'b00, 3'b010, 2'b11, 1));
    step(1, 8'h00, e_fetch(2));
    step(1, I_OR,  e_idle(2));
    step(1, 8'h00, e_exec(3'b100, 2'b10, 2'b00, 2));
    step(0, 8'h00, e_wb(4'b1000, 2'b00, 3'b100, 2'b10, 2));
    step(0, 8'h00, e_idle(3));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back got %h exp %h", o, e); end
    end
  endtask

  task automatic test_wrap();
    rec_t e, o;
    logic [7:0] c = 8'd0;
    do_reset();
    step(1, 8'h00, e_fetch(c));
    for (int k = 0; k < 256; k++) begin
      step(1, I_NOP, e_idle(c));
      c = c + 8'd1;
      step(1, 8'h00, e_fetch(c));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL wrap got %h exp %h", o, e); end
    end
    checks++;
    if (bus.RetCnt !== 8'd0) begin errors++; $display("FAIL wrap_final got %0d exp 0", bus.RetCnt); end
  endtask

  initial begin
    bus.Run   = 1'b0;
    bus.Instr = 8'h00;
    test_reset();
    test_add();
    test_ldi();
    test_nop_hlt();
    test_run_drop();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
